aes_core_param: RTL and testbench



---
 rtl/aes_pkg.sv | 57 +++++
 rtl/aes_round_comb.sv | 32 +++
 rtl/aes_core_param.sv | 157 +++++++++++++++
 tb/tb_aes_core_param.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box table, GF(2^8) helpers, MixColumns and the
// control FSM encoding used by the iterative cores.
package aes_pkg;

    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE   = 2'd0;
    localparam fsm_state_t ST_KEYEXP = 2'd1;
    localparam fsm_state_t ST_ROUND  = 2'd2;
    localparam fsm_state_t ST_OUT    = 2'd3;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] word);
        return {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One full AES encryption round as pure combinational logic:
// SubBytes, ShiftRows, MixColumns (skipped on the last round), AddRoundKey.
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic [127:0] state_out
);

    logic [127:0] shifted;
    logic [127:0] mixed;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        shifted = '0;
        mixed   = '0;
        // Byte n sits at [127-8n -: 8]; row r, column c is byte 4c+r.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127 - 8 * (4 * c + r) -: 8] =
                    sbox(state_in[127 - 8 * (4 * ((c + r) % 4) + r) -: 8]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            mixed[127 - 32 * c -: 32] = mix_column(shifted[127 - 32 * c -: 32]);
        end
        state_out = (last_round ? shifted : mixed) ^ round_key;
    end

endmodule

// File: rtl/aes_core_param.sv
// Iterative AES-128/192/256 encryption core with on-chip key expansion
// (one schedule word per cycle) and one round per cycle behind valid/ready.
// Optional macro AES_ROUND_KEY_OUT_EN exports the full round-key schedule.
module aes_core_param
    import aes_pkg::*;
#(
    parameter  int KEY_BITS = 128,
    localparam int NK       = KEY_BITS / 32,
    localparam int NR       = NK + 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [KEY_BITS-1:0]   i_key,
    input  logic                  i_start_key_schedule,
    output logic                  o_done_key_schedule,
    output logic                  o_key_valid,
    input  logic [127:0]          i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [127:0]          o_data,
    output logic                  o_valid,
`ifdef AES_ROUND_KEY_OUT_EN
    output logic [128*(NR+1)-1:0] o_round_key,
`endif
    input  logic                  i_ready
);

    localparam int         NW        = 4 * (NR + 1);
    localparam logic [5:0] NK_IDX    = 6'(NK);
    localparam logic [5:0] LAST_IDX  = 6'(NW - 1);
    localparam logic [2:0] LAST_KMOD = 3'(NK - 1);
    localparam logic [3:0] LAST_RND  = 4'(NR);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_core_param: KEY_BITS must be 128, 192 or 256");
    end

    fsm_state_t   fsm;
    logic [31:0]  w [NW];
    logic [5:0]   key_idx;
    logic [2:0]   kmod;
    logic [7:0]   rcon;
    logic [127:0] blk_state;
    logic [3:0]   rnd;

    logic [31:0]  prev_word;
    logic [31:0]  temp_word;
    logic [31:0]  new_word;
    logic [5:0]   rk_base;
    logic [127:0] rk_first;
    logic [127:0] rk_cur;
    logic [127:0] round_out;
    logic         last_round;

    // Next schedule word w[i] from w[i-1] and w[i-NK]; kmod tracks i mod NK.
    always_comb begin
        prev_word = w[key_idx - 6'd1];
        temp_word = prev_word;
        if (kmod == 3'd0) begin
            temp_word = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon, 24'h000000};
        end else if (NK == 8 && kmod == 3'd4) begin
            temp_word = sub_word(prev_word);
        end
        new_word = w[key_idx - NK_IDX] ^ temp_word;
    end

    assign rk_base    = {rnd, 2'b00};
    assign rk_first   = {w[0], w[1], w[2], w[3]};
    assign rk_cur     = {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};
    assign last_round = (rnd == LAST_RND);
    assign o_ready    = (fsm == ST_IDLE) && o_key_valid;

    aes_round_comb u_round (
        .state_in   (blk_state),
        .round_key  (rk_cur),
        .last_round (last_round),
        .state_out  (round_out)
    );

`ifdef AES_ROUND_KEY_OUT_EN
    for (genvar r = 0; r <= NR; r++) begin : g_rk_out
        assign o_round_key[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fsm                 <= ST_IDLE;
            // NOTE: the schedule store is cleared on reset so an aborted key can never be reused.
            for (int j = 0; j < NW; j++) begin
                w[j] <= '0;
            end
            key_idx             <= '0;
            kmod                <= '0;
            rcon                <= RCON_INIT;
            blk_state           <= '0;
            rnd                 <= '0;
            o_data              <= '0;
            o_valid             <= 1'b0;
            o_done_key_schedule <= 1'b0;
            o_key_valid         <= 1'b0;
        end else begin
            o_done_key_schedule <= 1'b0;
            case (fsm)
                ST_IDLE: begin
                    // A new key request wins over a plaintext offered in the same cycle.
                    if (i_start_key_schedule) begin
                        for (int j = 0; j < NK; j++) begin
                            w[j] <= i_key[KEY_BITS - 1 - 32 * j -: 32];
                        end
                        key_idx     <= NK_IDX;
                        kmod        <= '0;
                        rcon        <= RCON_INIT;
                        o_key_valid <= 1'b0;
                        fsm         <= ST_KEYEXP;
                    end else if (i_valid && o_ready) begin
                        blk_state <= i_data ^ rk_first;
                        rnd       <= 4'd1;
                        fsm       <= ST_ROUND;
                    end
                end
                ST_KEYEXP: begin
                    w[key_idx] <= new_word;
                    key_idx    <= key_idx + 6'd1;
                    kmod       <= (kmod == LAST_KMOD) ? 3'd0 : kmod + 3'd1;
                    if (kmod == 3'd0) begin
                        rcon <= xtime(rcon);
                    end
                    if (key_idx == LAST_IDX) begin
                        o_done_key_schedule <= 1'b1;
                        o_key_valid         <= 1'b1;
                        fsm                 <= ST_IDLE;
                    end
                end
                ST_ROUND: begin
                    if (last_round) begin
                        o_data  <= round_out;
                        o_valid <= 1'b1;
                        rnd     <= '0;
                        fsm     <= ST_OUT;
                    end else begin
                        blk_state <= round_out;
                        rnd       <= rnd + 4'd1;
                    end
                end
                ST_OUT: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        fsm     <= ST_IDLE;
                    end
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_core_param.sv
// Directed bench for aes_core_param at all three key sizes, with a ciphertext
// scoreboard, latency/throughput, backpressure and mid-operation reset checks.
module tb_aes_core_param;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [255:0] key_v       [3];
    logic         start_v     [3];
    logic         done_v      [3];
    logic         kv_v        [3];
    logic [127:0] din_v       [3];
    logic [127:0] dout_v      [3];
    logic         valid_in_v  [3];
    logic         ready_out_v [3];
    logic         valid_out_v [3];
    logic         ready_in_v  [3];

    int           vectors     = 0;
    int           miscompares = 0;
    int           cyc         = 0;
    logic [127:0] sb [$];

    always @(posedge clk) cyc <= cyc + 1;

`ifdef AES_ROUND_KEY_OUT_EN
    logic [128*11-1:0] rk_128;
    logic [128*13-1:0] rk_192;
    logic [128*15-1:0] rk_256;
`endif

    aes_core_param #(.KEY_BITS(128)) u_dut128 (
        .i_clk(clk), .i_rst_n(rst_n), .i_key(key_v[0][127:0]),
        .i_start_key_schedule(start_v[0]), .o_done_key_schedule(done_v[0]),
        .o_key_valid(kv_v[0]), .i_data(din_v[0]), .i_valid(valid_in_v[0]),
        .o_ready(ready_out_v[0]), .o_data(dout_v[0]), .o_valid(valid_out_v[0]),
`ifdef AES_ROUND_KEY_OUT_EN
        .o_round_key(rk_128),
`endif
        .i_ready(ready_in_v[0])
    );

    aes_core_param #(.KEY_BITS(192)) u_dut192 (
        .i_clk(clk), .i_rst_n(rst_n), .i_key(key_v[1][191:0]),
        .i_start_key_schedule(start_v[1]), .o_done_key_schedule(done_v[1]),
        .o_key_valid(kv_v[1]), .i_data(din_v[1]), .i_valid(valid_in_v[1]),
        .o_ready(ready_out_v[1]), .o_data(dout_v[1]), .o_valid(valid_out_v[1]),
`ifdef AES_ROUND_KEY_OUT_EN
        .o_round_key(rk_192),
`endif
        .i_ready(ready_in_v[1])
    );

    aes_core_param #(.KEY_BITS(256)) u_dut256 (
        .i_clk(clk), .i_rst_n(rst_n), .i_key(key_v[2]),
        .i_start_key_schedule(start_v[2]), .o_done_key_schedule(done_v[2]),
        .o_key_valid(kv_v[2]), .i_data(din_v[2]), .i_valid(valid_in_v[2]),
        .o_ready(ready_out_v[2]), .o_data(dout_v[2]), .o_valid(valid_out_v[2]),
`ifdef AES_ROUND_KEY_OUT_EN
        .o_round_key(rk_256),
`endif
        .i_ready(ready_in_v[2])
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse the schedule start and measure cycles to the done pulse (start edge's cycle = 1).
    task automatic run_key(input int k, input logic [255:0] key, input int exp_lat,
                           input bit with_valid, input string tag);
        int n;
        @(negedge clk);
        key_v[k]   = key;
        start_v[k] = 1'b1;
        if (with_valid) valid_in_v[k] = 1'b1;
        @(posedge clk);
        #1;
        start_v[k]    = 1'b0;
        valid_in_v[k] = 1'b0;
        key_v[k]      = ~key;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_v[k] && n < 200);
        check({tag, "_done_lat"}, 256'(n), 256'(exp_lat));
        check({tag, "_key_valid"}, 256'(kv_v[k]), 256'(1));
        @(negedge clk);
        check({tag, "_done_pulse"}, 256'({done_v[k], valid_out_v[k]}), 256'(0));
    endtask

    task automatic send_block(input int k, input logic [127:0] pt, input logic [127:0] ct);
        int n;
        @(negedge clk);
        din_v[k]      = pt;
        valid_in_v[k] = 1'b1;
        sb.push_back(ct);
        n = 0;
        while (!ready_out_v[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("accept_timeout", 256'(n), 256'(0));
        @(posedge clk);
        #1;
        valid_in_v[k] = 1'b0;
        din_v[k]      = ~pt;
    endtask

    // Called just after the accept edge; the first following negedge is cycle 1.
    task automatic collect(input int k, input int exp_lat, input string tag);
        int n;
        logic [127:0] exp_ct;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid_out_v[k] && n < 100);
        check({tag, "_valid_lat"}, 256'(n), 256'(exp_lat));
        if (sb.size() > 0) exp_ct = sb.pop_front();
        else exp_ct = 'x;
        check({tag, "_ct"}, 256'(dout_v[k]), 256'(exp_ct));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [127:0] pts [3];
        logic [127:0] cts [3];
        int           t_acc [3];
        int           n;
        bit           ok;

        pts[0] = 128'h6bc1bee22e409f96e93d7e117393172a; cts[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        pts[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51; cts[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
        pts[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef; cts[2] = 128'h43b1cd7f598ece23881b00e3ed030688;

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            key_v[k] = '0; start_v[k] = 1'b0; din_v[k] = '0;
            valid_in_v[k] = 1'b0; ready_in_v[k] = 1'b1;
        end
        #12;
        check("reset_outputs", 256'({done_v[0], kv_v[0], ready_out_v[0], valid_out_v[0], dout_v[0]}), 256'(0));
        check("reset_kv_192_256", 256'({kv_v[1], kv_v[2], ready_out_v[1], ready_out_v[2]}), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // FIPS-197 Appendix C vectors at each key size.
        run_key(0, 256'h000102030405060708090a0b0c0d0e0f, 41, 1'b0, "k128");
        send_block(0, 128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        collect(0, 11, "c128");

        run_key(1, 256'h000102030405060708090a0b0c0d0e0f1011121314151617, 47, 1'b0, "k192");
        send_block(1, 128'h00112233445566778899aabbccddeeff, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
        collect(1, 13, "c192");

        run_key(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 53, 1'b0, "k256");
        send_block(2, 128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089);
        collect(2, 15, "c256");

        // Plaintext offered alongside the start pulse must lose to the schedule.
        run_key(0, 256'h2b7e151628aed2a6abf7158809cf4f3c, 41, 1'b1, "k_prio");
`ifdef AES_ROUND_KEY_OUT_EN
        check("rk0",  256'(rk_128[127:0]),     256'h2b7e151628aed2a6abf7158809cf4f3c);
        check("rk1",  256'(rk_128[255:128]),   256'ha0fafe1788542cb123a339392a6c7605);
        check("rk10", 256'(rk_128[1407:1280]), 256'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`endif

        // Three back-to-back blocks with i_valid held high.
        @(negedge clk);
        valid_in_v[0] = 1'b1;
        din_v[0]      = pts[0];
        sb.push_back(cts[0]);
        for (int j = 0; j < 3; j++) begin
            n = 0;
            while (!ready_out_v[0] && n < 100) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk);
            #1;
            t_acc[j] = cyc;
            if (j < 2) begin
                din_v[0] = pts[j + 1];
                sb.push_back(cts[j + 1]);
            end else begin
                valid_in_v[0] = 1'b0;
            end
            collect(0, 11, "b2b");
        end
        check("b2b_period_01", 256'(t_acc[1] - t_acc[0]), 256'(12));
        check("b2b_period_12", 256'(t_acc[2] - t_acc[1]), 256'(12));

        // Output backpressure: hold i_ready low for 20 cycles in OUT.
        run_key(0, 256'h129cd242996d818ca55c2abbff0ddc61, 41, 1'b0, "k_bp");
        ready_in_v[0] = 1'b0;
        send_block(0, 128'h1a120000000000000000000000000000, 128'ha35b3cb11eb233638fd2aa248ffdd579);
        collect(0, 11, "bp");
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!(valid_out_v[0] && !ready_out_v[0] &&
                  dout_v[0] == 128'ha35b3cb11eb233638fd2aa248ffdd579)) ok = 1'b0;
        end
        check("bp_hold_stable", 256'(ok), 256'(1));
        ready_in_v[0] = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", 256'({valid_out_v[0], ready_out_v[0]}), 256'(2'b01));

        // Reset in the middle of ROUND.
        send_block(0, 128'h1a120000000000000000000000000000, 128'ha35b3cb11eb233638fd2aa248ffdd579);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_round_outputs",
              256'({done_v[0], kv_v[0], ready_out_v[0], valid_out_v[0], dout_v[0]}), 256'(0));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        valid_in_v[0] = 1'b1;
        din_v[0]      = 128'h00112233445566778899aabbccddeeff;
        ok = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (valid_out_v[0] || ready_out_v[0] || kv_v[0]) ok = 1'b1;
        end
        check("rst_no_accept", 256'(ok), 256'(0));
        valid_in_v[0] = 1'b0;

        // Reset in the middle of KEYEXP, then recover with a fresh schedule.
        @(negedge clk);
        key_v[0]   = 256'h000102030405060708090a0b0c0d0e0f;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_keyexp_outputs",
              256'({done_v[0], kv_v[0], ready_out_v[0], valid_out_v[0], dout_v[0]}), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_key(0, 256'h000102030405060708090a0b0c0d0e0f, 41, 1'b0, "k_recover");
        send_block(0, 128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        collect(0, 11, "c_recover");

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
